axi_id_slot_alloc: RTL and testbench

AXI_ID_SLOT_ALLOC -- requirements
Module: axi_id_slot_alloc

---
 rtl/slv_pkg.sv | 12 +
 rtl/lzc.sv | 21 ++
 rtl/axi_id_slot_alloc.sv | 119 +++++++++++
 tb/tb_axi_id_slot_alloc.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/slv_pkg.sv
// Shared defaults and ID types for the AXI ID slot allocator.
package slv_pkg;

  localparam int unsigned MaxUniqIds    = 2;
  localparam int unsigned MaxTxnsPerId  = 4;
  localparam int unsigned AxiIdWidth    = 6;
  localparam int unsigned AxiIntIdWidth = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1;

  typedef logic [AxiIdWidth-1:0]    id_t;
  typedef logic [AxiIntIdWidth-1:0] intid_t;

endpackage

// File: rtl/lzc.sv
// Trailing-zero counter: index of the lowest set bit of in_i; empty_o when no bit is set.
module lzc #(
  parameter int unsigned Width = 2,
  localparam int unsigned CntWidth = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0]    in_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                empty_o
);

  always_comb begin
    cnt_o = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (in_i[i]) cnt_o = CntWidth'(i);
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/axi_id_slot_alloc.sv
// Maps external AXI IDs onto a small pool of internal ID slots, keeping same-ID traffic
// on one slot so response ordering is preserved.
module axi_id_slot_alloc #(
  parameter int unsigned MaxUniqIds   = slv_pkg::MaxUniqIds,
  parameter int unsigned MaxTxnsPerId = slv_pkg::MaxTxnsPerId,
  parameter int unsigned AxiIdWidth   = slv_pkg::AxiIdWidth,
  localparam int unsigned IntIdWidth  = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1,
  localparam int unsigned CntW        = $clog2(MaxTxnsPerId + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alloc_valid_i,
  input  logic [AxiIdWidth-1:0] alloc_id_i,
  output logic                  alloc_ready_o,
  output logic [IntIdWidth-1:0] alloc_intid_o,
  input  logic                  rel_valid_i,
  input  logic [IntIdWidth-1:0] rel_intid_i,
  output logic [AxiIdWidth-1:0] rel_id_o,
  output logic                  rel_err_o,
  output logic                  full_o,
  output logic                  idle_o
);

  localparam logic [CntW-1:0] CntMax = CntW'(MaxTxnsPerId);

  logic [MaxUniqIds-1:0] valid_q, valid_d;
  logic [AxiIdWidth-1:0] id_q  [MaxUniqIds];
  logic [AxiIdWidth-1:0] id_d  [MaxUniqIds];
  logic [CntW-1:0]       cnt_q [MaxUniqIds];
  logic [CntW-1:0]       cnt_d [MaxUniqIds];
  logic                  rel_err_q, rel_err_d;

  logic [MaxUniqIds-1:0] free_vec, inc_vec, dec_vec;
  logic [IntIdWidth-1:0] free_idx, match_idx;
  logic                  no_free, match, match_full, rel_hit;

  assign free_vec = ~valid_q;

  lzc #(
    .Width (MaxUniqIds)
  ) u_free_lzc (
    .in_i    (free_vec),
    .cnt_o   (free_idx),
    .empty_o (no_free)
  );

  // At most one valid slot ever holds a given ID, so the match is unique.
  always_comb begin
    match      = 1'b0;
    match_idx  = '0;
    match_full = 1'b0;
    for (int unsigned i = 0; i < MaxUniqIds; i++) begin
      if (valid_q[i] && (id_q[i] == alloc_id_i)) begin
        match      = 1'b1;
        match_idx  = IntIdWidth'(i);
        match_full = (cnt_q[i] == CntMax);
      end
    end
  end

  assign alloc_ready_o = alloc_valid_i && (match ? !match_full : !no_free);
  assign alloc_intid_o = match ? match_idx : free_idx;

  always_comb begin
    rel_id_o = '0;
    rel_hit  = 1'b0;
    for (int unsigned i = 0; i < MaxUniqIds; i++) begin
      if (rel_intid_i == IntIdWidth'(i)) begin
        rel_id_o = id_q[i];
        rel_hit  = valid_q[i];
      end
    end
  end

  assign rel_err_d = rel_valid_i && !rel_hit;

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned i = 0; i < MaxUniqIds; i++) begin
      inc_vec[i] = alloc_ready_o && (alloc_intid_o == IntIdWidth'(i));
      dec_vec[i] = rel_valid_i && (rel_intid_i == IntIdWidth'(i)) && valid_q[i];
      // Alloc and release on the same slot cancel; the slot stays open.
      if (inc_vec[i] && !dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
        if (!valid_q[i]) id_d[i] = alloc_id_i;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        cnt_d[i] = cnt_q[i] - CntW'(1);
      end
      valid_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= '0;
      rel_err_q <= 1'b0;
      for (int unsigned i = 0; i < MaxUniqIds; i++) begin
        id_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      rel_err_q <= rel_err_d;
      for (int unsigned i = 0; i < MaxUniqIds; i++) begin
        id_q[i]  <= id_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rel_err_o = rel_err_q;
  assign full_o    = &valid_q;
  assign idle_o    = ~|valid_q;

endmodule

// File: tb/tb_axi_id_slot_alloc.sv
// Directed vector bench for axi_id_slot_alloc with default parameters (2 slots, 4 txns, 6-bit ID).
module tb_axi_id_slot_alloc;
  import slv_pkg::*;

  logic   clk = 1'b0;
  logic   rst_ni;
  logic   alloc_valid;
  id_t    alloc_id;
  logic   alloc_ready;
  intid_t alloc_intid;
  logic   rel_valid;
  intid_t rel_intid;
  id_t    rel_id;
  logic   rel_err, full, idle;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  axi_id_slot_alloc dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .alloc_valid_i (alloc_valid),
    .alloc_id_i    (alloc_id),
    .alloc_ready_o (alloc_ready),
    .alloc_intid_o (alloc_intid),
    .rel_valid_i   (rel_valid),
    .rel_intid_i   (rel_intid),
    .rel_id_o      (rel_id),
    .rel_err_o     (rel_err),
    .full_o        (full),
    .idle_o        (idle)
  );

  typedef struct {
    logic   av;
    id_t    aid;
    logic   rv;
    intid_t rid;
    logic   e_ready;
    intid_t e_intid;
    logic   chk_relid;
    id_t    e_relid;
    logic   e_full;
    logic   e_idle;
    logic   e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic av, id_t aid, logic rv, intid_t rid, logic e_ready,
                              intid_t e_intid, logic chk_relid, id_t e_relid,
                              logic e_full, logic e_idle, logic e_err);
    vec_t v;
    v.av = av; v.aid = aid; v.rv = rv; v.rid = rid;
    v.e_ready = e_ready; v.e_intid = e_intid; v.chk_relid = chk_relid; v.e_relid = e_relid;
    v.e_full = e_full; v.e_idle = e_idle; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(int idx, vec_t v);
    alloc_valid = v.av;
    alloc_id    = v.aid;
    rel_valid   = v.rv;
    rel_intid   = v.rid;
    @(negedge clk);
    nvec++;
    chk($sformatf("v%0d ready", idx), 32'(alloc_ready), 32'(v.e_ready));
    if (v.e_ready) chk($sformatf("v%0d intid", idx), 32'(alloc_intid), 32'(v.e_intid));
    if (v.chk_relid) chk($sformatf("v%0d rel_id", idx), 32'(rel_id), 32'(v.e_relid));
    chk($sformatf("v%0d full", idx), 32'(full), 32'(v.e_full));
    chk($sformatf("v%0d idle", idx), 32'(idle), 32'(v.e_idle));
    chk($sformatf("v%0d rel_err", idx), 32'(rel_err), 32'(v.e_err));
    @(posedge clk);
    #1;
  endtask

  initial begin
    //               av  aid    rv rid rdy int crel relid  full idle err
    // basic alloc/release of 0x2A
    vecs.push_back(mk(0, 6'h00, 0, 0, 0, 0, 0, 6'h00, 0, 1, 0));
    vecs.push_back(mk(1, 6'h2A, 0, 0, 1, 0, 0, 6'h00, 0, 1, 0));
    vecs.push_back(mk(0, 6'h00, 1, 0, 0, 0, 1, 6'h2A, 0, 0, 0));
    vecs.push_back(mk(0, 6'h00, 0, 0, 0, 0, 0, 6'h00, 0, 1, 0));
    // per-ID limit: four 0x05 accepted, fifth stalls without opening slot 1
    vecs.push_back(mk(1, 6'h05, 0, 0, 1, 0, 0, 6'h00, 0, 1, 0));
    vecs.push_back(mk(1, 6'h05, 0, 0, 1, 0, 0, 6'h00, 0, 0, 0));
    vecs.push_back(mk(1, 6'h05, 0, 0, 1, 0, 0, 6'h00, 0, 0, 0));
    vecs.push_back(mk(1, 6'h05, 0, 0, 1, 0, 0, 6'h00, 0, 0, 0));
    vecs.push_back(mk(1, 6'h05, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0));
    vecs.push_back(mk(1, 6'h05, 1, 0, 0, 0, 1, 6'h05, 0, 0, 0));
    vecs.push_back(mk(1, 6'h05, 0, 0, 1, 0, 0, 6'h00, 0, 0, 0));
    vecs.push_back(mk(0, 6'h00, 1, 0, 0, 0, 1, 6'h05, 0, 0, 0));
    vecs.push_back(mk(0, 6'h00, 1, 0, 0, 0, 1, 6'h05, 0, 0, 0));
    vecs.push_back(mk(0, 6'h00, 1, 0, 0, 0, 1, 6'h05, 0, 0, 0));
    vecs.push_back(mk(0, 6'h00, 1, 0, 0, 0, 1, 6'h05, 0, 0, 0));
    vecs.push_back(mk(0, 6'h00, 0, 0, 0, 0, 0, 6'h00, 0, 1, 0));
    // full: 0x01, 0x02 outstanding, 0x03 waits until slot 0 drains
    vecs.push_back(mk(1, 6'h01, 0, 0, 1, 0, 0, 6'h00, 0, 1, 0));
    vecs.push_back(mk(1, 6'h02, 0, 0, 1, 1, 0, 6'h00, 0, 0, 0));
    vecs.push_back(mk(1, 6'h03, 0, 0, 0, 0, 0, 6'h00, 1, 0, 0));
    vecs.push_back(mk(1, 6'h03, 1, 0, 0, 0, 1, 6'h01, 1, 0, 0));
    vecs.push_back(mk(1, 6'h03, 0, 0, 1, 0, 0, 6'h00, 0, 0, 0));
    vecs.push_back(mk(0, 6'h00, 1, 1, 0, 0, 1, 6'h02, 1, 0, 0));
    vecs.push_back(mk(0, 6'h00, 1, 0, 0, 0, 1, 6'h03, 0, 0, 0));
    vecs.push_back(mk(0, 6'h00, 0, 0, 0, 0, 0, 6'h00, 0, 1, 0));
    // simultaneous alloc + release on a count-1 slot keeps it open at count 1
    vecs.push_back(mk(1, 6'h07, 0, 0, 1, 0, 0, 6'h00, 0, 1, 0));
    vecs.push_back(mk(1, 6'h07, 1, 0, 1, 0, 1, 6'h07, 0, 0, 0));
    vecs.push_back(mk(0, 6'h00, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0));
    vecs.push_back(mk(0, 6'h00, 1, 0, 0, 0, 1, 6'h07, 0, 0, 0));
    vecs.push_back(mk(0, 6'h00, 0, 0, 0, 0, 0, 6'h00, 0, 1, 0));
    // release of empty slot 1: one-cycle error pulse, nothing else changes
    vecs.push_back(mk(0, 6'h00, 1, 1, 0, 0, 0, 6'h00, 0, 1, 0));
    vecs.push_back(mk(0, 6'h00, 0, 0, 0, 0, 0, 6'h00, 0, 1, 1));
    vecs.push_back(mk(0, 6'h00, 0, 0, 0, 0, 0, 6'h00, 0, 1, 0));
    vecs.push_back(mk(1, 6'h2B, 0, 0, 1, 0, 0, 6'h00, 0, 1, 0));

    rst_ni      = 1'b0;
    alloc_valid = 1'b0;
    alloc_id    = '0;
    rel_valid   = 1'b0;
    rel_intid   = '0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;

    foreach (vecs[i]) apply(i, vecs[i]);

    // Mid-operation reset with three transactions outstanding (slot 0 has 0x2B from above).
    alloc_valid = 1'b0;
    rel_valid   = 1'b1;
    rel_intid   = 1'b0;
    @(posedge clk);
    #1;
    rel_valid   = 1'b0;
    alloc_valid = 1'b1;
    alloc_id    = 6'h11;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    alloc_id = 6'h22;
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    nvec++;
    chk("pre_rst full", 32'(full), 32'd1);
    chk("pre_rst idle", 32'(idle), 32'd0);
    #2 rst_ni = 1'b0;
    #1;
    nvec++;
    chk("in_rst idle", 32'(idle), 32'd1);
    chk("in_rst full", 32'(full), 32'd0);
    chk("in_rst rel_err", 32'(rel_err), 32'd0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    alloc_valid = 1'b1;
    alloc_id    = 6'h3F;
    @(negedge clk);
    nvec++;
    chk("post_rst ready", 32'(alloc_ready), 32'd1);
    chk("post_rst intid", 32'(alloc_intid), 32'd0);
    @(posedge clk);
    #1 alloc_valid = 1'b0;
    @(negedge clk);
    nvec++;
    chk("post_rst idle", 32'(idle), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
